if_prefetch_queue: RTL and testbench

IF_PREFETCH_QUEUE -- requirements
Module: if_prefetch_queue

---
 rtl/core_pkg.sv | 16 +
 rtl/prefetch_fifo.sv | 81 ++++++++
 rtl/if_prefetch_queue.sv | 161 ++++++++++++++++
 tb/tb_if_prefetch_queue.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: datapath width, reset vector and the fetch entry record.
package core_pkg;

    // Address and instruction width of the core
    localparam int unsigned XLEN = 32;

    // First fetch address after reset
    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

    // One prefetched instruction together with the address it was fetched from
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/prefetch_fifo.sv
// Small synchronous FIFO with registered pointers and occupancy count.
// A push while full is accepted only if a pop happens in the same cycle.
// flush empties the FIFO and takes priority over push and pop.
module prefetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Status flags and the effective push/pop after full/empty qualification
    always_comb begin
        empty   = (count_q == '0);
        full    = (count_q == DEPTH_C);
        count   = count_q;
        rdata   = mem[rptr_q];
        do_pop  = pop && !empty;
        do_push = push && (!full || pop);
    end

    // Pointer and count next state; DEPTH is a power of two so pointers wrap naturally
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) begin
                wptr_d = wptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rptr_d = rptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Pointer and count registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage array; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction-fetch prefetch queue. Issues word fetches ahead of decode, tracking
// in-flight requests with credits so that every response always has a free slot.
// A redirect flushes the queue, restarts fetch at the target and discards the
// responses of requests already in flight. XLEN must match core_pkg::XLEN because
// queue entries use core_pkg::fetch_entry_t.
module if_prefetch_queue #(
    parameter int unsigned     XLEN     = core_pkg::XLEN,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = core_pkg::RESET_PC
) (
    input  logic            clk,
    input  logic            rstn,
    // Instruction memory request channel
    output logic            o_imem_req_valid,
    input  logic            i_imem_req_ready,
    output logic [XLEN-1:0] o_imem_req_addr,
    // Instruction memory response channel (in order, latency >= 1)
    input  logic            i_imem_rsp_valid,
    input  logic [XLEN-1:0] i_imem_rsp_data,
    // Taken branch / jump from EX
    input  logic            i_redirect_valid,
    input  logic [XLEN-1:0] i_redirect_pc,
    // Head of queue towards IF-ID
    output logic            o_instr_valid,
    output logic [XLEN-1:0] o_instr,
    output logic [XLEN-1:0] o_instr_pc,
    input  logic            i_instr_ready,
    output logic            o_empty
);

    import core_pkg::*;

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W:0] CREDITS = (CNT_W + 1)'(DEPTH);

    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0] outst_q, outst_d;
    logic [CNT_W-1:0] drop_q, drop_d;

    logic [CNT_W:0]   credit_used;
    logic             credit_ok;
    logic             req_fire;
    logic             rsp_drop;
    logic             rsp_keep;

    fetch_entry_t     entry_wdata;
    fetch_entry_t     entry_rdata;
    logic             entry_push;
    logic             entry_pop;
    logic             entry_empty;
    logic             entry_full;
    logic [CNT_W-1:0] occ;

    logic [XLEN-1:0]  pc_rdata;
    logic             pc_empty;
    logic             pc_full;
    logic [CNT_W-1:0] pc_count;

    // Request issue: queued plus in-flight never exceeds DEPTH, so a response always fits.
    // Gating with rstn keeps the request low while reset is held.
    always_comb begin
        credit_used      = {1'b0, occ} + {1'b0, outst_q};
        credit_ok        = (credit_used < CREDITS);
        o_imem_req_valid = rstn && credit_ok && !i_redirect_valid;
        o_imem_req_addr  = fetch_pc_q;
        req_fire         = o_imem_req_valid && i_imem_req_ready;
    end

    // Response routing and queue handshake towards IF-ID
    always_comb begin
        // Responses belonging to pre-redirect requests, or arriving with a redirect, are dropped
        rsp_drop          = i_imem_rsp_valid && (i_redirect_valid || (drop_q != '0));
        rsp_keep          = i_imem_rsp_valid && !rsp_drop;
        entry_push        = rsp_keep;
        entry_wdata.pc    = pc_rdata;
        entry_wdata.instr = i_imem_rsp_data;
        o_instr_valid     = !entry_empty && !i_redirect_valid;
        entry_pop         = o_instr_valid && i_instr_ready;
        o_instr           = entry_rdata.instr;
        o_instr_pc        = entry_rdata.pc;
        o_empty           = entry_empty;
    end

    // Fetch PC, in-flight and drop counter next state
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        drop_d     = drop_q;
        outst_d    = outst_q + CNT_W'(req_fire) - CNT_W'(i_imem_rsp_valid);
        if (req_fire) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
        end
        if (i_redirect_valid) begin
            fetch_pc_d = {i_redirect_pc[XLEN-1:2], 2'b00};
            // Everything still in flight after this cycle's response belongs to the old path
            drop_d     = outst_q - CNT_W'(i_imem_rsp_valid);
        end else if (rsp_drop) begin
            drop_d = drop_q - CNT_W'(1);
        end
    end

    // Fetch control registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fetch_pc_q <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
        end
    end

    // Fetched instructions waiting for decode
    prefetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_entry_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .flush (i_redirect_valid),
        .push  (entry_push),
        .wdata (entry_wdata),
        .pop   (entry_pop),
        .rdata (entry_rdata),
        .empty (entry_empty),
        .full  (entry_full),
        .count (occ)
    );

    // Address of each in-flight request; popped by every response, dropped or kept,
    // so its head always pairs with the next returning instruction
    prefetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (XLEN)
    ) u_pc_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .flush (1'b0),
        .push  (req_fire),
        .wdata (fetch_pc_q),
        .pop   (i_imem_rsp_valid),
        .rdata (pc_rdata),
        .empty (pc_empty),
        .full  (pc_full),
        .count (pc_count)
    );

    a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
        !(entry_push && entry_full && !entry_pop));

    a_no_stray_rsp: assert property (@(posedge clk) disable iff (!rstn)
        !(i_imem_rsp_valid && pc_empty));

    a_pc_fifo_room: assert property (@(posedge clk) disable iff (!rstn)
        !(req_fire && pc_full));

    a_pc_tracks_outst: assert property (@(posedge clk) disable iff (!rstn)
        (pc_count == outst_q) && (drop_q <= outst_q));

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Bench for if_prefetch_queue: a memory model with programmable latency and a grant budget,
// directed scenarios that push the hand-derived PC stream into a scoreboard queue, and a
// monitor that pops and compares every instruction handed to IF-ID.
module tb_if_prefetch_queue;

    localparam logic [31:0] MAGIC = 32'hC0DE_0000;

    logic        clk;
    logic        rstn;
    logic        o_imem_req_valid;
    logic        i_imem_req_ready;
    logic [31:0] o_imem_req_addr;
    logic        i_imem_rsp_valid;
    logic [31:0] i_imem_rsp_data;
    logic        i_redirect_valid;
    logic [31:0] i_redirect_pc;
    logic        o_instr_valid;
    logic [31:0] o_instr;
    logic [31:0] o_instr_pc;
    logic        i_instr_ready;
    logic        o_empty;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    exp_t  exp_q[$];
    pend_t pend[$];

    int total;
    int bad;
    int cyc;
    int mem_lat;
    int granted;
    int accepted;
    bit stall;

    if_prefetch_queue dut (
        .clk              (clk),
        .rstn             (rstn),
        .o_imem_req_valid (o_imem_req_valid),
        .i_imem_req_ready (i_imem_req_ready),
        .o_imem_req_addr  (o_imem_req_addr),
        .i_imem_rsp_valid (i_imem_rsp_valid),
        .i_imem_rsp_data  (i_imem_rsp_data),
        .i_redirect_valid (i_redirect_valid),
        .i_redirect_pc    (i_redirect_pc),
        .o_instr_valid    (o_instr_valid),
        .o_instr          (o_instr),
        .o_instr_pc       (o_instr_pc),
        .i_instr_ready    (i_instr_ready),
        .o_empty          (o_empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Memory: drives ready/response just after the edge, records handshakes at the falling edge
    initial begin
        accepted         = 0;
        i_imem_req_ready = 1'b0;
        i_imem_rsp_valid = 1'b0;
        i_imem_rsp_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            i_imem_req_ready = (accepted != granted) && !stall;
            if (rstn && pend.size() != 0 && pend[0].due == cyc + 1) begin
                i_imem_rsp_valid = 1'b1;
                i_imem_rsp_data  = pend[0].addr ^ MAGIC;
                void'(pend.pop_front());
            end else begin
                i_imem_rsp_valid = 1'b0;
            end
            @(negedge clk);
            if (!rstn) begin
                pend.delete();
                i_imem_rsp_valid = 1'b0;
            end else if (o_imem_req_valid && i_imem_req_ready) begin
                pend.push_back('{addr: o_imem_req_addr, due: cyc + 1 + mem_lat});
                accepted++;
            end
        end
    end

    // Monitor: every IF-ID handshake is checked against the scoreboard head
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rstn && o_instr_valid && i_instr_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_extra: got pc %h, no entry expected", o_instr_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_pc", o_instr_pc, e.pc);
                    chk("sb_instr", o_instr, e.instr);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic expect_run(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{pc: base + 32'(4 * i), instr: (base + 32'(4 * i)) ^ MAGIC});
        end
    endtask

    task automatic apply_reset();
        step(1);
        rstn = 1'b0;
        step(3);
    endtask

    // Grant is set during reset; one more edge lets ready settle before release
    task automatic release_reset();
        step(1);
        rstn = 1'b1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            step(1);
            n++;
        end
        chk(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        int a0;
        int n;
        total            = 0;
        bad              = 0;
        rstn             = 1'b0;
        i_instr_ready    = 1'b0;
        i_redirect_valid = 1'b0;
        i_redirect_pc    = '0;
        stall            = 1'b0;
        granted          = 0;
        mem_lat          = 1;

        // Reset values
        step(2);
        @(negedge clk);
        chk("rst_req_valid", 32'(o_imem_req_valid), 32'd0);
        chk("rst_instr_valid", 32'(o_instr_valid), 32'd0);
        chk("rst_empty", 32'(o_empty), 32'd1);

        // Streaming at latency 1: first request right after release, output 2 cycles later
        apply_reset();
        mem_lat       = 1;
        i_instr_ready = 1'b1;
        granted       = accepted + 8;
        expect_run(32'h0, 8);
        release_reset();
        @(negedge clk);
        chk("a_first_req_valid", 32'(o_imem_req_valid), 32'd1);
        chk("a_first_req_addr", o_imem_req_addr, 32'h0);
        chk("a_fill0_valid", 32'(o_instr_valid), 32'd0);
        step(1);
        @(negedge clk);
        chk("a_fill1_valid", 32'(o_instr_valid), 32'd0);
        for (int i = 0; i < 8; i++) begin
            step(1);
            @(negedge clk);
            chk("a_stream_valid", 32'(o_instr_valid), 32'd1);
        end
        drain("a_drain");

        // Decode stalled: exactly DEPTH requests, then the queue is full and fetch stops
        apply_reset();
        mem_lat       = 1;
        i_instr_ready = 1'b0;
        granted       = accepted + 10;
        expect_run(32'h0, 10);
        a0 = accepted;
        release_reset();
        step(20);
        @(negedge clk);
        chk("b_req_count", 32'(accepted - a0), 32'd4);
        chk("b_req_valid", 32'(o_imem_req_valid), 32'd0);
        chk("b_empty", 32'(o_empty), 32'd0);
        chk("b_head_pc", o_instr_pc, 32'h0);
        step(1);
        i_instr_ready = 1'b1;
        drain("b_drain");

        // Latency 3, redirect with two requests in flight: both responses dropped
        apply_reset();
        mem_lat       = 3;
        i_instr_ready = 1'b1;
        granted       = accepted;
        release_reset();
        step(2);
        a0      = accepted;
        granted = accepted + 2;
        n = 0;
        while (accepted != a0 + 2 && n < 20) begin
            step(1);
            n++;
        end
        chk("c_inflight", 32'(accepted - a0), 32'd2);
        i_redirect_valid = 1'b1;
        i_redirect_pc    = 32'h100;
        granted          = accepted + 4;
        expect_run(32'h100, 4);
        @(negedge clk);
        chk("c_redir_req_valid", 32'(o_imem_req_valid), 32'd0);
        step(1);
        i_redirect_valid = 1'b0;
        @(negedge clk);
        chk("c_target_req_valid", 32'(o_imem_req_valid), 32'd1);
        chk("c_target_addr", o_imem_req_addr, 32'h100);
        drain("c_drain");

        // Redirect coinciding with a response and a would-be dequeue
        apply_reset();
        mem_lat       = 1;
        i_instr_ready = 1'b1;
        granted       = accepted + 6;
        expect_run(32'h0, 1);
        expect_run(32'h200, 3);
        release_reset();
        step(3);
        i_redirect_valid = 1'b1;
        i_redirect_pc    = 32'h200;
        @(negedge clk);
        chk("d_rsp_present", 32'(i_imem_rsp_valid), 32'd1);
        chk("d_instr_valid_gated", 32'(o_instr_valid), 32'd0);
        step(1);
        i_redirect_valid = 1'b0;
        @(negedge clk);
        chk("d_empty_after", 32'(o_empty), 32'd1);
        drain("d_drain");

        // Memory not ready for 5 cycles: address held at 0x8
        apply_reset();
        mem_lat       = 1;
        i_instr_ready = 1'b1;
        granted       = accepted + 6;
        expect_run(32'h0, 6);
        release_reset();
        step(1);
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1);
            @(negedge clk);
            chk("e_hold_valid", 32'(o_imem_req_valid), 32'd1);
            chk("e_hold_addr", o_imem_req_addr, 32'h8);
        end
        stall = 1'b0;
        drain("e_drain");

        // Reset pulse with three entries queued
        apply_reset();
        mem_lat       = 1;
        i_instr_ready = 1'b0;
        granted       = accepted + 3;
        release_reset();
        step(8);
        @(negedge clk);
        chk("f_queued_empty", 32'(o_empty), 32'd0);
        chk("f_queued_head", o_instr_pc, 32'h0);
        step(1);
        rstn = 1'b0;
        #1;
        chk("f_rst_req_valid", 32'(o_imem_req_valid), 32'd0);
        chk("f_rst_instr_valid", 32'(o_instr_valid), 32'd0);
        chk("f_rst_empty", 32'(o_empty), 32'd1);
        granted       = accepted + 2;
        i_instr_ready = 1'b1;
        expect_run(32'h0, 2);
        step(2);
        rstn = 1'b1;
        @(negedge clk);
        chk("f_restart_valid", 32'(o_imem_req_valid), 32'd1);
        chk("f_restart_addr", o_imem_req_addr, 32'h0);
        drain("f_drain");

        step(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
